// File: rtl/sram_async_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_async_ctrl
// Brief    : Synchronous valid/ready initiator for a 256K x 16 asynchronous
//            SRAM. Sequences CE_/OE_/WE_/LB_/UB_, address and data-bus drive
//            enable with programmable read/write wait states. All outputs
//            are registered.
// Options  : define SRAM_CTRL_TURNAROUND_EN to insert one TURN clock (all
//            strobes high) after every read before returning to IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module sram_async_ctrl #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);

    // Wait-state counter is sized for the longer of the two strobe phases.
    localparam int c_MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);
    localparam int c_LANE_W  = DATA_W / 2;

    localparam logic [c_CNT_W-1:0] c_RD_LAST = c_CNT_W'(RD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LAST = c_CNT_W'(WR_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_RD       = 3'd1;
    localparam logic [2:0] c_WR_SETUP = 3'd2;
    localparam logic [2:0] c_WR_PULSE = 3'd3;
    localparam logic [2:0] c_WR_HOLD  = 3'd4;
`ifdef SRAM_CTRL_TURNAROUND_EN
    localparam logic [2:0] c_TURN     = 3'd5;
`endif

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_be;
    logic [DATA_W-1:0]  w_lane_mask;

    // Disabled byte lanes read back as zero.
    assign w_lane_mask = {{c_LANE_W{r_be[1]}}, {c_LANE_W{r_be[0]}}};

    // Controller FSM; every pin and response output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_be       <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            sram_a     <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        sram_a    <= req_addr;
                        r_be      <= req_be;
                        r_cnt     <= '0;
                        sram_ce_n <= 1'b0;
                        sram_lb_n <= ~req_be[0];
                        sram_ub_n <= ~req_be[1];
                        if (req_we) begin
                            r_state    <= c_WR_SETUP;
                            sram_dq_o  <= req_wdata;
                            sram_dq_oe <= 1'b1;
                        end else begin
                            r_state   <= c_RD;
                            sram_oe_n <= 1'b0;
                        end
                    end else begin
                        // Covers the first clock after reset release.
                        req_ready <= 1'b1;
                    end
                end
                c_RD: begin
                    if (r_cnt == c_RD_LAST) begin
                        rsp_rdata <= sram_dq_i & w_lane_mask;
                        rsp_valid <= 1'b1;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                        sram_ub_n <= 1'b1;
`ifdef SRAM_CTRL_TURNAROUND_EN
                        r_state   <= c_TURN;
`else
                        r_state   <= c_IDLE;
                        req_ready <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_WR_SETUP: begin
                    r_state   <= c_WR_PULSE;
                    r_cnt     <= '0;
                    sram_we_n <= 1'b0;
                end
                c_WR_PULSE: begin
                    if (r_cnt == c_WR_LAST) begin
                        r_state   <= c_WR_HOLD;
                        sram_we_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_WR_HOLD: begin
                    r_state    <= c_IDLE;
                    req_ready  <= 1'b1;
                    sram_ce_n  <= 1'b1;
                    sram_lb_n  <= 1'b1;
                    sram_ub_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end
`ifdef SRAM_CTRL_TURNAROUND_EN
                c_TURN: begin
                    // Strobes are already high; this clock lets the SRAM
                    // release the bus before a write may drive it.
                    r_state   <= c_IDLE;
                    req_ready <= 1'b1;
                end
`endif
                default: begin
                    r_state    <= c_IDLE;
                    req_ready  <= 1'b0;
                    sram_dq_oe <= 1'b0;
                    sram_ce_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                    sram_we_n  <= 1'b1;
                    sram_lb_n  <= 1'b1;
                    sram_ub_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_async_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_async_ctrl
// Brief    : Self-checking bench for sram_async_ctrl: pin-level SRAM model,
//            word-level reference memory, directed and random transactions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_async_ctrl;

    localparam int RD = 2;
    localparam int WR = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [17:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [17:0] sram_a;
    logic [15:0] sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    // second instance, RD_CYCLES = 3
    logic        d3_valid, d3_ready, d3_we;
    logic [17:0] d3_addr;
    logic [15:0] d3_wdata;
    logic [1:0]  d3_be;
    logic        d3_rsp_valid;
    logic [15:0] d3_rdata;
    logic [17:0] d3_a;
    logic [15:0] d3_dq_o, d3_dq_i;
    logic        d3_dq_oe, d3_ce_n, d3_oe_n, d3_we_n, d3_lb_n, d3_ub_n;

    always #5 clk = ~clk;

    sram_async_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .sram_a(sram_a),
        .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
    );

    sram_async_ctrl #(.RD_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(d3_valid), .req_ready(d3_ready),
        .req_we(d3_we), .req_addr(d3_addr), .req_wdata(d3_wdata), .req_be(d3_be),
        .rsp_valid(d3_rsp_valid), .rsp_rdata(d3_rdata), .sram_a(d3_a),
        .sram_dq_o(d3_dq_o), .sram_dq_oe(d3_dq_oe), .sram_dq_i(d3_dq_i),
        .sram_ce_n(d3_ce_n), .sram_oe_n(d3_oe_n), .sram_we_n(d3_we_n),
        .sram_lb_n(d3_lb_n), .sram_ub_n(d3_ub_n)
    );

    // Pin-level SRAM: drives data while CE_ and OE_ are low, latches on WE_ rising.
    logic [15:0] sram_mem [0:262143] = '{default: 16'h0000};
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_a] : 16'hDEAD;
    assign d3_dq_i   = (!d3_ce_n && !d3_oe_n) ? 16'h5A3C : 16'hDEAD;

    always @(posedge sram_we_n) begin
        if (sram_ce_n === 1'b0) begin
            if (!sram_lb_n) sram_mem[sram_a][7:0]  <= sram_dq_oe ? sram_dq_o[7:0]  : 8'hEE;
            if (!sram_ub_n) sram_mem[sram_a][15:8] <= sram_dq_oe ? sram_dq_o[15:8] : 8'hEE;
        end
    end

    // Bus monitors: contention, and CE_ high between OE_ release and drive.
    int contention = 0;
    int gap_bad    = 0;
    logic pend = 1'b0, ce_hi = 1'b0;
    always @(negedge clk) begin
        if (sram_dq_oe && !sram_oe_n) contention <= contention + 1;
        if (d3_dq_oe && !d3_oe_n)     contention <= contention + 1;
        if (!sram_oe_n) begin
            pend  <= 1'b1;
            ce_hi <= 1'b0;
        end else if (pend) begin
            if (sram_dq_oe) begin
                if (!ce_hi) gap_bad <= gap_bad + 1;
                pend <= 1'b0;
            end else if (sram_ce_n) begin
                ce_hi <= 1'b1;
            end
        end
    end

    // Word-level reference memory.
    logic [15:0] ref_mem [logic [17:0]];

    function automatic logic [15:0] ref_read(input logic [17:0] a, input logic [1:0] be);
        logic [15:0] w;
        w = ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
        if (!be[0]) w[7:0]  = 8'h00;
        if (!be[1]) w[15:8] = 8'h00;
        return w;
    endfunction

    task automatic ref_write(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be);
        logic [15:0] w;
        w = ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
        if (be[0]) w[7:0]  = d[7:0];
        if (be[1]) w[15:8] = d[15:8];
        ref_mem[a] = w;
    endtask

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          x_wait, x_rsp_at, x_busy, x_we_lo, x_oe_lo, x_lane_lo;
    logic [15:0] x_rd;
    logic        x_c1_ce, x_c1_we, x_c1_dqoe;
    logic [17:0] x_c1_a;
    logic [15:0] x_c1_dq;

    // Present a request and return in the first clock after acceptance.
    task automatic accept(input logic we, input logic [17:0] a, input logic [15:0] wd,
                          input logic [1:0] be);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        x_wait = 0;
        while (!req_ready && x_wait < 20) begin
            tick();
            x_wait++;
        end
        check("accept_timeout", 32'(x_wait < 20), 32'd1);
        tick();
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = $urandom;
    endtask

    task automatic xact(input logic we, input logic [17:0] a, input logic [15:0] wd,
                        input logic [1:0] be);
        accept(we, a, wd, be);
        x_rsp_at = -1; x_busy = 0; x_we_lo = 0; x_oe_lo = 0; x_lane_lo = 0; x_rd = '0;
        x_c1_ce = sram_ce_n; x_c1_we = sram_we_n; x_c1_dqoe = sram_dq_oe;
        x_c1_a = sram_a; x_c1_dq = sram_dq_o;
        for (int c = 1; c <= 12; c++) begin
            if (rsp_valid && x_rsp_at < 0) begin
                x_rsp_at = c;
                x_rd     = rsp_rdata;
            end
            if (!req_ready && x_busy == c - 1) x_busy = c;
            if (!sram_we_n) x_we_lo++;
            if (!sram_oe_n) x_oe_lo++;
            if (!sram_lb_n || !sram_ub_n) x_lane_lo++;
            if (req_ready && (we || x_rsp_at >= 0)) break;
            tick();
        end
        if (we) ref_write(a, wd, be);
    endtask

    task automatic chk_read(input string tag, input logic [17:0] a, input logic [1:0] be);
        xact(1'b0, a, 16'h0, be);
        check({tag, "_data"}, 32'(x_rd), 32'(ref_read(a, be)));
        check({tag, "_lat"}, 32'(x_rsp_at), 32'(RD + 1));
        check({tag, "_busy"}, 32'(x_busy), 32'(RD));
        check({tag, "_oe_lo"}, 32'(x_oe_lo), 32'(RD));
    endtask

    task automatic chk_write(input string tag, input logic [17:0] a, input logic [15:0] d,
                             input logic [1:0] be);
        xact(1'b1, a, d, be);
        check({tag, "_busy"}, 32'(x_busy), 32'(WR + 2));
        check({tag, "_we_lo"}, 32'(x_we_lo), 32'(WR));
        check({tag, "_norsp"}, 32'(x_rsp_at), 32'hFFFF_FFFF);
    endtask

    logic [17:0] pool [6] = '{18'h00000, 18'h3FFFF, 18'h12345, 18'h00010, 18'h2B0C1, 18'h00011};
    int          seen;
    logic [15:0] held;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        d3_valid = 1'b0; d3_we = 1'b0; d3_addr = '0; d3_wdata = '0; d3_be = '0;

        // Reset values
        repeat (3) tick();
        check("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp", {15'd0, rsp_valid, rsp_rdata}, 32'd0);
        check("rst_addr_dq", {sram_a[15:0], sram_dq_o}, 32'd0);
        rst_n = 1'b1;
        check("rel_ready0", 32'(req_ready), 32'd0);
        tick();
        check("rel_ready1", 32'(req_ready), 32'd1);

        // Full-word write then read
        chk_write("wr_full", 18'h12345, 16'hA5C3, 2'b11);
        check("wr_setup_pins", {x_c1_ce, x_c1_we, x_c1_dqoe}, 32'b011);
        check("wr_setup_a", 32'(x_c1_a), 32'h12345);
        check("wr_setup_dq", 32'(x_c1_dq), 32'hA5C3);
        chk_read("rd_full", 18'h12345, 2'b11);
        check("rd_full_const", 32'(x_rd), 32'hA5C3);

        // Byte-lane masking
        chk_write("wr_ffff", 18'h00010, 16'hFFFF, 2'b11);
        chk_write("wr_hi", 18'h00010, 16'h1200, 2'b10);
        chk_read("rd_be11", 18'h00010, 2'b11);
        check("rd_be11_const", 32'(x_rd), 32'h12FF);
        chk_read("rd_be01", 18'h00010, 2'b01);
        check("rd_be01_const", 32'(x_rd), 32'h00FF);

        // Read data holds through a following write; back-to-back acceptance
        held = rsp_rdata;
        chk_write("b2b_wr", 18'h00011, 16'h0BAD, 2'b11);
        check("b2b_nowait", 32'(x_wait), 32'd0);
        check("rdata_hold", 32'(rsp_rdata), 32'(held));

        // be=00: full cycle, no lanes, zero data
        xact(1'b0, 18'h12345, 16'h0, 2'b00);
        check("be00_data", 32'(x_rd), 32'd0);
        check("be00_lat", 32'(x_rsp_at), 32'(RD + 1));
        check("be00_lanes", 32'(x_lane_lo), 32'd0);

        // Random traffic against the reference memory
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                chk_write("rnd_wr", pool[$urandom_range(0, 5)], 16'($urandom), 2'($urandom));
            else
                chk_read("rnd_rd", pool[$urandom_range(0, 5)], 2'($urandom));
        end

        // Reset during WR_PULSE
        accept(1'b1, 18'h2AAAA, 16'h7777, 2'b11);
        tick();
        check("mid_wr_pulse", 32'(sram_we_n), 32'd0);
        rst_n = 1'b0;
        tick();
        check("mid_wr_rst", {29'd0, sram_we_n, sram_ce_n, sram_dq_oe}, 32'b110);
        rst_n = 1'b1;
        tick();
        check("mid_wr_ready", 32'(req_ready), 32'd1);

        // Reset during RD: response dropped
        accept(1'b0, 18'h12345, 16'h0, 2'b11);
        check("mid_rd_oe", 32'(sram_oe_n), 32'd0);
        rst_n = 1'b0;
        tick();
        check("mid_rd_rst", {30'd0, sram_oe_n, rsp_valid}, 32'b10);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            tick();
            if (rsp_valid) seen++;
        end
        check("mid_rd_norsp", 32'(seen), 32'd0);
        check("mid_rd_ready", 32'(req_ready), 32'd1);
        chk_read("post_rst_rd", 18'h12345, 2'b11);

        // Top address on the RD_CYCLES=3 instance
        d3_valid = 1'b1; d3_addr = 18'h3FFFF; d3_be = 2'b11;
        x_wait = 0;
        while (!d3_ready && x_wait < 20) begin
            tick();
            x_wait++;
        end
        check("d3_accept_timeout", 32'(x_wait < 20), 32'd1);
        tick();
        d3_valid = 1'b0;
        check("d3_addr", 32'(d3_a), 32'h3FFFF);
        x_rsp_at = -1; x_oe_lo = 0; x_rd = '0;
        for (int c = 1; c <= 12; c++) begin
            if (!d3_oe_n) x_oe_lo++;
            if (d3_rsp_valid && x_rsp_at < 0) begin
                x_rsp_at = c;
                x_rd     = d3_rdata;
            end
            tick();
        end
        check("d3_oe_lo", 32'(x_oe_lo), 32'd3);
        check("d3_lat", 32'(x_rsp_at), 32'd4);
        check("d3_data", 32'(x_rd), 32'h5A3C);

        // Bus monitors
        check("contention", 32'(contention), 32'd0);
        check("ce_gap", 32'(gap_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
